// File: rtl/sine_generator.sv
// -----------------------------------------------------------------------------
// sine_generator
//   Full-scale signed 16-bit test tone built from a 33-entry quarter-wave LUT.
//   There are 128 samples per period. The sample rate is the system clock
//   divided by 2^psc_i.
//
// Ports
//   clk_i   in   1   system clock, all state updates on the rising edge
//   rst_i   in   1   synchronous active-high reset (cnt, phase, output -> 0)
//   psc_i   in   4   prescaler exponent: one sample step every 2^psc_i clocks
//   sine_o  out  16  registered sine sample, two's complement
// -----------------------------------------------------------------------------
module sine_generator (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [3:0]         psc_i,
   output logic signed [15:0] sine_o
);

   logic [14:0]        cnt_q, cnt_d;
   logic [6:0]         ph_q, ph_d;
   logic signed [15:0] sine_q, sine_d;
   logic [14:0]        term_cnt;
   logic               tick;

   // round(32767 * sin(2*pi*a/128)) for a = 0..32
   function automatic logic [14:0] quarter_lut(input logic [5:0] a);
      logic [14:0] v;
      case (a)
         6'd0:    v = 15'd0;
         6'd1:    v = 15'd1608;
         6'd2:    v = 15'd3212;
         6'd3:    v = 15'd4808;
         6'd4:    v = 15'd6393;
         6'd5:    v = 15'd7962;
         6'd6:    v = 15'd9512;
         6'd7:    v = 15'd11039;
         6'd8:    v = 15'd12539;
         6'd9:    v = 15'd14010;
         6'd10:   v = 15'd15446;
         6'd11:   v = 15'd16846;
         6'd12:   v = 15'd18204;
         6'd13:   v = 15'd19519;
         6'd14:   v = 15'd20787;
         6'd15:   v = 15'd22005;
         6'd16:   v = 15'd23170;
         6'd17:   v = 15'd24279;
         6'd18:   v = 15'd25329;
         6'd19:   v = 15'd26319;
         6'd20:   v = 15'd27245;
         6'd21:   v = 15'd28105;
         6'd22:   v = 15'd28898;
         6'd23:   v = 15'd29621;
         6'd24:   v = 15'd30273;
         6'd25:   v = 15'd30852;
         6'd26:   v = 15'd31356;
         6'd27:   v = 15'd31785;
         6'd28:   v = 15'd32137;
         6'd29:   v = 15'd32412;
         6'd30:   v = 15'd32609;
         6'd31:   v = 15'd32728;
         6'd32:   v = 15'd32767;
         default: v = 15'd0;
      endcase
      return v;
   endfunction

   // Quadrant decode. n[5] mirrors the index (L[32-a]) and n[6] negates.
   // The magnitude never exceeds 32767, so -32768 cannot be produced.
   function automatic logic signed [15:0] sample(input logic [6:0] n);
      logic [5:0]         a;
      logic signed [15:0] mag;
      a   = n[5] ? (6'd32 - {1'b0, n[4:0]}) : {1'b0, n[4:0]};
      mag = $signed({1'b0, quarter_lut(a)});
      return n[6] ? -mag : mag;
   endfunction

   // Terminal count 2^psc_i - 1, as a run of psc_i low ones.
   // It follows psc_i live. The >= compare forces an immediate tick when the
   // rate is raised while the count is already past the new limit.
   assign term_cnt = ~(15'h7fff << psc_i);
   assign tick     = (cnt_q >= term_cnt);

   always_comb begin
      cnt_d  = cnt_q + 15'd1;
      ph_d   = ph_q;
      sine_d = sine_q;
      if (tick) begin
         cnt_d  = 15'd0;
         ph_d   = ph_q + 7'd1;
         sine_d = sample(ph_q + 7'd1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= 15'd0;
         ph_q   <= 7'd0;
         sine_q <= 16'sd0;
      end else begin
         cnt_q  <= cnt_d;
         ph_q   <= ph_d;
         sine_q <= sine_d;
      end
   end

   assign sine_o = sine_q;

endmodule

// File: tb/tb_sine_generator.sv
module tb_sine_generator;

   logic               clk = 1'b0;
   logic               rst;
   logic [3:0]         psc;
   logic signed [15:0] sine;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state.
   int m_cnt, m_ph, m_out;
   int obs [0:127];

   always #5 clk = ~clk;

   sine_generator dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .psc_i  (psc),
      .sine_o (sine)
   );

   function automatic int ref_s(input int n);
      real r;
      r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(n) / 128.0);
      if (r >= 0.0) return $rtoi(r + 0.5);
      else          return -$rtoi(-r + 0.5);
   endfunction

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One clock edge. The reference advances with the inputs present at that
   // edge, and the DUT output is then compared 1 time unit later.
   task automatic step();
      int s;
      @(posedge clk);
      if (rst) begin
         m_cnt = 0; m_ph = 0; m_out = 0;
      end else if (m_cnt >= (1 << psc) - 1) begin
         m_cnt = 0;
         m_ph  = (m_ph + 1) % 128;
         m_out = ref_s(m_ph);
      end else begin
         m_cnt++;
      end
      #1;
      s = int'(sine);
      check("sine", s, m_out);
      if (s > 32767 || s < -32767) check("range", s, 0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset(input logic [3:0] p);
      rst = 1'b1; psc = p;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int guard;
      rst = 1'b1; psc = 4'd4;
      m_cnt = 0; m_ph = 0; m_out = 0;

      // Reset held for 3 cycles, then first step at edge 16 with psc=4.
      steps(3);
      check("reset_val", int'(sine), 0);
      rst = 1'b0;
      steps(15);
      check("psc4_edge15", int'(sine), 0);
      step();
      check("psc4_edge16", int'(sine), 1608);
      steps(2048 - 16);
      check("psc4_period", int'(sine), 0);

      // psc=0: one full period plus symmetry of the observed waveform.
      do_reset(4'd0);
      for (int k = 1; k <= 128; k++) begin
         step();
         obs[k % 128] = int'(sine);
      end
      check("p0_s1",   obs[1],   1608);
      check("p0_s16",  obs[16],  23170);
      check("p0_s32",  obs[32],  32767);
      check("p0_s64",  obs[64],  0);
      check("p0_s96",  obs[96],  -32767);
      check("p0_s127", obs[127], -1608);
      check("p0_wrap", obs[0],   0);
      for (int n = 0; n < 64; n++)  check("odd_sym",  obs[n], -obs[n + 64]);
      for (int n = 0; n <= 32; n++) check("half_sym", obs[n], obs[64 - n]);

      // Slower rates: a few samples each.
      do_reset(4'd6);
      steps(63);
      check("psc6_edge63", int'(sine), 0);
      step();
      check("psc6_edge64", int'(sine), 1608);
      steps(128);
      check("psc6_edge192", int'(sine), 4808);
      do_reset(4'd8);
      steps(512);
      check("psc8_edge512", int'(sine), 3212);

      // Rate switch down from psc 10 with cnt = 800.
      do_reset(4'd10);
      steps(800);
      psc = 4'd4;
      step();
      check("switch_tick", int'(sine), 1608);
      steps(15);
      check("switch_hold", int'(sine), 1608);
      step();
      check("switch_next", int'(sine), 3212);

      // Mid-run reset during the negative half-cycle at psc 10.
      psc   = 4'd0;
      guard = 0;
      while (m_ph != 70 && guard < 200) begin
         step();
         guard++;
      end
      check("reach_neg_timeout", int'(guard < 200), 1);
      psc = 4'd10;
      steps(300);
      check("neg_half", int'(sine < 0), 1);
      rst = 1'b1;
      step();
      check("midrst_zero", int'(sine), 0);
      rst = 1'b0;
      steps(1023);
      check("midrst_edge1023", int'(sine), 0);
      step();
      check("midrst_edge1024", int'(sine), 1608);

      // Randomised rate changes and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 63) == 0) psc = 4'($urandom_range(0, 6));
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;

      // Slowest rate: the first step lands on edge 32768.
      do_reset(4'd15);
      steps(32767);
      check("psc15_edge32767", int'(sine), 0);
      step();
      check("psc15_edge32768", int'(sine), 1608);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
